// File: rtl/led_scanner.sv
// LED pattern scanner: steps a pattern register on every toggle of the blink bit.
// Modes are hold, rotate left, rotate right, and bounce. Applied steps are counted.
module led_scanner #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             B_in,
   input  logic [1:0]       mode,
   input  logic             pause,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] led,
   output logic             dir,
   output logic [7:0]       step_count
);

   typedef enum logic [1:0] {
      MODE_HOLD   = 2'b00,
      MODE_ROT_L  = 2'b01,
      MODE_ROT_R  = 2'b10,
      MODE_BOUNCE = 2'b11
   } mode_e;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   localparam logic [WIDTH-1:0] LED_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic             b_prev_q, b_prev_d;
   logic [WIDTH-1:0] led_q, led_d;
   dir_e             dir_q, dir_d;
   logic [7:0]       cnt_q, cnt_d;

   logic             tick;
   logic             step;
   mode_e            mode_sel;
   logic [WIDTH-1:0] rot_l, rot_r, shl, shr;

   // Neighbour wiring for the rotate and zero-filled shift variants.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_shift
         if (gi == 0) begin : g_lsb
            assign rot_l[gi] = led_q[WIDTH-1];
            assign shl[gi]   = 1'b0;
         end else begin : g_lsb_n
            assign rot_l[gi] = led_q[gi-1];
            assign shl[gi]   = led_q[gi-1];
         end
         if (gi == WIDTH-1) begin : g_msb
            assign rot_r[gi] = led_q[0];
            assign shr[gi]   = 1'b0;
         end else begin : g_msb_n
            assign rot_r[gi] = led_q[gi+1];
            assign shr[gi]   = led_q[gi+1];
         end
      end
   endgenerate

   assign mode_sel = mode_e'(mode);
   assign tick     = B_in ^ b_prev_q;
   assign step     = tick & ~pause & ~load & (mode_sel != MODE_HOLD);

   always_comb begin
      b_prev_d = B_in;
      led_d    = led_q;
      dir_d    = dir_q;
      cnt_d    = cnt_q;
      if (load) begin
         led_d = load_val;
      end else if (step) begin
         cnt_d = cnt_q + 8'd1;
         if (led_q == '0) begin
            led_d = LED_ONE;
         end else begin
            case (mode_sel)
               MODE_ROT_L: led_d = rot_l;
               MODE_ROT_R: led_d = rot_r;
               MODE_BOUNCE: begin
                  if (dir_q == DIR_LEFT) begin
                     if (led_q[WIDTH-1]) begin
                        dir_d = DIR_RIGHT;
                        led_d = shr;
                     end else begin
                        led_d = shl;
                     end
                  end else begin
                     if (led_q[0]) begin
                        dir_d = DIR_LEFT;
                        led_d = shl;
                     end else begin
                        led_d = shr;
                     end
                  end
               end
               default: led_d = led_q;
            endcase
         end
      end
   end

   // Reset still samples B_in so the first cycle after release sees no tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         b_prev_q <= B_in;
         led_q    <= LED_ONE;
         dir_q    <= DIR_LEFT;
         cnt_q    <= 8'd0;
      end else begin
         b_prev_q <= b_prev_d;
         led_q    <= led_d;
         dir_q    <= dir_d;
         cnt_q    <= cnt_d;
      end
   end

   assign led        = led_q;
   assign dir        = dir_q;
   assign step_count = cnt_q;

endmodule

// File: doc/led_scanner.md
# led_scanner

Downstream consumer of the blink-rate toggle bit. Every transition of the slow square wave on `B_in` is one step event. On each step the block advances an LED pattern register by one position: hold, rotate left, rotate right, or bounce. It also counts the steps it applies. It sits between the blink divider and the board LED pins, in the same `clk` domain as the divider.

## Interface
- `WIDTH`, default 8: LED pattern width; legal range 2..16.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `B_in`  in  1  blink toggle bit from the divider; updated on negedge `clk`, so it is stable at posedge.
- `mode`  in  2  pattern mode: 00 HOLD, 01 ROT_L, 10 ROT_R, 11 BOUNCE.
- `pause`  in  1  1 = ignore step events.
- `load`  in  1  1 = load `load_val` into the pattern this cycle.
- `load_val`  in  WIDTH  pattern to load.
- `led`  out  WIDTH  current pattern, registered.
- `dir`  out  1  bounce direction, registered: 0 = LEFT (toward MSB), 1 = RIGHT.
- `step_count`  out  8  number of applied steps, registered, wraps.

## Operation
- Edge tracking:
  - Register `b_prev` samples `B_in` every posedge, including while paused.
  - `tick = B_in ^ b_prev`, so both rising and falling toggles count as steps.
  - No synchronizer: `B_in` comes from the same clock, half a cycle earlier.
- Reset (`rst`=1 at posedge):
  - `led` = 1 (LSB set), `dir` = 0, `step_count` = 0.
  - `b_prev` <= `B_in`, so no spurious tick after reset.
  - Reset overrides `load`, `tick` and `pause`.
- Priority each posedge: `rst` > `load` > applied step.
- `load`=1:
  - `led` <= `load_val`.
  - `dir` and `step_count` are unchanged.
  - A coincident tick is discarded, not deferred.
- Applied step = `tick` & ~`pause` & ~`load` & (`mode` != HOLD).
  - `step_count` += 1 mod 256.
  - `led` updates per mode.
- If `led` == 0 at an applied step, `led` <= 1 and `dir` is unchanged. This recovery replaces the normal mode action.
- ROT_L: circular rotate toward MSB; MSB wraps to LSB. `dir` unchanged.
- ROT_R: circular rotate toward LSB; LSB wraps to MSB. `dir` unchanged.
- BOUNCE, a 2-state FSM held in `dir`:
  - LEFT:
    - If `led[WIDTH-1]`=1: `dir` <= RIGHT and `led` <= `led` >> 1.
    - Else: `led` <= `led` << 1 (logical shift).
  - RIGHT:
    - If `led[0]`=1: `dir` <= LEFT and `led` <= `led` << 1.
    - Else: `led` <= `led` >> 1.
  - Shifts are logical and zero-filled. Non-one-hot patterns may lose bits at the ends; the zero-recovery rule restores a single 1.
- HOLD: ticks consumed, `led` and `step_count` unchanged.
- Mode changes take effect at the next applied step. `dir` persists across mode changes.
- `pause`: ticks consumed and dropped. Deasserting `pause` never produces a burst of steps.

## Timing
- `B_in` toggles at negedge N; the new `led` is visible after the immediately following posedge. Latency is a half cycle, with at most one step per toggle.
- Back-to-back toggles on consecutive cycles give one step per cycle.
- `load` takes effect at the posedge where it is sampled high; `led` shows `load_val` the following cycle.
- All outputs are direct register outputs, with no combinational path from inputs.
- `step_count` wraps 255 -> 0 on the 256th applied step with no flag.

## Test plan
- Reset: drive `rst`=1 for 2 cycles with `B_in`=1 -> `led`=0x01, `dir`=0, `step_count`=0; no step on the first cycle after release.
- ROT_L, WIDTH=8: from 0x01, apply 8 toggles -> `led` 0x02, 0x04 … 0x80, then 0x01; `step_count`=8.
- BOUNCE: from 0x01, `dir`=0, apply 9 toggles -> 0x02 … 0x80 on the 7th toggle, 0x40 with `dir`=1 on the 8th, 0x20 on the 9th.
- Load vs tick: assert `load` with `load_val`=0xA5 in the same cycle as a toggle, in ROT_R -> `led`=0xA5, `step_count` unchanged. The next toggle gives 0xD2.
- Pause and zero recovery:
  - `pause`=1 across 3 toggles -> no change.
  - Release `pause` -> no step until the next toggle.
  - Load 0x00, then toggle -> `led`=0x01.
- Mid-operation reset: assert `rst` in the same cycle as a toggle and `load` -> reset values win. `step_count` wrap: 256 applied steps -> `step_count`=0.
